// File: rtl/pc_sequencer.sv
// pc_sequencer
// ----------------------------------------------------------------------------
// Program-counter and run-control stage for a single-cycle CPU datapath.
// Owns the architectural PC and the executed-instruction counter, and
// provides start / halt / single-step control plus end-of-program detection.
//
// Parameters:
//   RESET_PC   - PC value after reset and after a restart from DONE.
//   MAX_INSTR  - executed-instruction limit (1..65535); reaching it ends the run.
//
// Ports:
//   clk          in   single clock, all state updates on the rising edge
//   rst          in   synchronous active-high reset
//   start        in   begin (IDLE), resume (PAUSE) or restart (DONE)
//   step_mode    in   sampled when leaving IDLE; 1 = enter PAUSE (single-step)
//   step         in   in PAUSE, executes one instruction in each cycle it is high
//   halt_req     in   in RUN, suppresses execution this cycle and pauses
//   end_addr     in   program end; the instruction at this address never runs
//   next_pc      in   next-sequential address from the CPU (PC+4)
//   pc           out  current instruction address
//   run_en       out  instruction at pc executes this cycle (gates RegWrite/MemWrite)
//   done         out  high while in DONE
//   instr_count  out  instructions executed since the last start from IDLE
// ----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [15:0] MAX_INSTR = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step_mode,
    input  logic        step,
    input  logic        halt_req,
    input  logic [31:0] end_addr,
    input  logic [31:0] next_pc,
    output logic [31:0] pc,
    output logic        run_en,
    output logic        done,
    output logic [15:0] instr_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]  state_reg;
    logic [1:0]  state_next;
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [15:0] count_reg;
    logic [15:0] count_next;
    logic        done_reg;
    logic        done_next;

    logic [31:0] aligned_pc;
    logic [15:0] count_inc;
    logic        exec_en;
    logic        unused_low_bits;

    // Word-align the CPU's next address: instruction fetches are always on
    // 4-byte boundaries, so the two low bits from the CPU are discarded.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi = gi + 1) begin : g_align
            if (gi < 2) begin : g_low
                assign aligned_pc[gi] = 1'b0;
            end else begin : g_high
                assign aligned_pc[gi] = next_pc[gi];
            end
        end
    endgenerate

    assign unused_low_bits = ^next_pc[1:0];

    assign count_inc = count_reg + 16'd1;

    // Execution qualifier. Reset forces it low so a reset edge never lets the
    // datapath commit architectural state.
    always_comb begin
        exec_en = 1'b0;
        if (!rst) begin
            if (state_reg == ST_RUN && !halt_req) begin
                exec_en = 1'b1;
            end else if (state_reg == ST_PAUSE && step) begin
                exec_en = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        count_next = count_reg;

        if (exec_en) begin
            // Retire one instruction. The end check is made on the new PC so
            // done rises on the same edge as the final PC update.
            pc_next    = aligned_pc;
            count_next = count_inc;
            if (aligned_pc == end_addr || count_inc == MAX_INSTR) begin
                state_next = ST_DONE;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        count_next = 16'd0;
                        if (pc_reg == end_addr) begin
                            // Empty program: nothing to execute.
                            state_next = ST_DONE;
                        end else if (step_mode) begin
                            state_next = ST_PAUSE;
                        end else begin
                            state_next = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // Only reachable here with halt_req high.
                    state_next = ST_PAUSE;
                end
                ST_PAUSE: begin
                    // step has priority; here step is low.
                    if (start) begin
                        state_next = ST_RUN;
                    end
                end
                ST_DONE: begin
                    // Count is kept for inspection until the next start from IDLE.
                    if (start) begin
                        state_next = ST_IDLE;
                        pc_next    = RESET_PC;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign done_next = (state_next == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            pc_reg    <= RESET_PC;
            count_reg <= 16'd0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            count_reg <= count_next;
            done_reg  <= done_next;
        end
    end

    assign pc          = pc_reg;
    assign run_en      = exec_en;
    assign done        = done_reg;
    assign instr_count = count_reg;

endmodule
